ci_initiator: RTL and testbench

- Master end of the custom-instruction (CI) handshake used by the CI slave blocks, such as the RAM/DMA CI.
- Accepts queued CI commands from a controller or test sequencer through a valid/ready port.
- Drives start/ciN/valueA/valueB to one CI slave and waits for done, with a timeout.
- Returns the captured result through a valid/ready response port; one CI is outstanding at a time.

---
 rtl/ci_initiator.sv | 149 ++++++++++++++
 tb/tb_ci_initiator.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ci_initiator.sv
// Custom-instruction initiator: queues CI commands, issues them one at a time to a CI slave,
// waits for done or a timeout, and returns the captured result on a valid/ready port.
module ci_initiator #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_ci_n,
  input  logic [31:0] cmd_value_a,
  input  logic [31:0] cmd_value_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        ci_start,
  output logic [7:0]  ci_n,
  output logic [31:0] ci_value_a,
  output logic [31:0] ci_value_b,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic        busy
);

  localparam int unsigned AddrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [71:0]      mem_q [FIFO_DEPTH];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             cmd_ready_q;
  logic             full_d;
  logic             empty;
  logic             push;
  logic             pop;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       ci_n_q, ci_n_d;
  logic [31:0]      ci_a_q, ci_a_d;
  logic [31:0]      ci_b_q, ci_b_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = cmd_valid & cmd_ready_q;
  assign pop   = (state_q == StIdle) & ~empty;

  assign wr_ptr_d = wr_ptr_q + {{AddrW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AddrW{1'b0}}, pop};

  // Ready is registered from the next-cycle occupancy, so it never depends on this cycle's pop.
  assign full_d = (wr_ptr_d[AddrW] != rd_ptr_d[AddrW]) &&
                  (wr_ptr_d[AddrW-1:0] == rd_ptr_d[AddrW-1:0]);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= {cmd_ci_n, cmd_value_a, cmd_value_b};
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ci_n_d        = ci_n_q;
    ci_a_d        = ci_a_q;
    ci_b_d        = ci_b_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          {ci_n_d, ci_a_d, ci_b_d} = mem_q[rd_ptr_q[AddrW-1:0]];
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = 16'd1;
        if (ci_done) begin
          rsp_result_d  = ci_result;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Done takes priority over an expiring timeout in the same cycle.
        if (ci_done) begin
          rsp_result_d  = ci_result;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (cnt_q == TimeoutVal) begin
          rsp_result_d  = 32'h0;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmd_ready_q   <= 1'b1;
      cnt_q         <= 16'd0;
      ci_n_q        <= 8'h0;
      ci_a_q        <= 32'h0;
      ci_b_q        <= 32'h0;
      rsp_result_q  <= 32'h0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cmd_ready_q   <= ~full_d;
      cnt_q         <= cnt_d;
      ci_n_q        <= ci_n_d;
      ci_a_q        <= ci_a_d;
      ci_b_q        <= ci_b_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = (state_q == StResp);
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign ci_start    = (state_q == StIssue);
  assign ci_n        = ci_n_q;
  assign ci_value_a  = ci_a_q;
  assign ci_value_b  = ci_b_q;
  assign busy        = (state_q != StIdle) | ~empty;

endmodule

// File: tb/tb_ci_initiator.sv
// Bench for ci_initiator: behavioural CI slave with programmable latency plus a
// transaction-level model of the responses each command must produce.
module tb_ci_initiator;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_ci_n = 8'h0;
  logic [31:0] cmd_value_a = 32'h0;
  logic [31:0] cmd_value_b = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic        ci_start;
  logic [7:0]  ci_n;
  logic [31:0] ci_value_a;
  logic [31:0] ci_value_b;
  logic [31:0] ci_result = 32'h0;
  logic        ci_done = 1'b0;
  logic        busy;

  ci_initiator #(
    .FIFO_DEPTH    (Depth),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ci_n   (cmd_ci_n),
    .cmd_value_a(cmd_value_a),
    .cmd_value_b(cmd_value_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_timeout(rsp_timeout),
    .ci_start   (ci_start),
    .ci_n       (ci_n),
    .ci_value_a (ci_value_a),
    .ci_value_b (ci_value_b),
    .ci_result  (ci_result),
    .ci_done    (ci_done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave configuration: sl_lat < 0 takes the latency from ci_n % 11.
  int          sl_lat = 1;
  bit          sl_res_fixed = 1'b0;
  logic [31:0] sl_res_val = 32'h0;

  function automatic logic [31:0] slave_fn(logic [7:0] n, logic [31:0] a, logic [31:0] b);
    return a + (b ^ {24'h0, n});
  endfunction

  function automatic int lat_of(logic [7:0] n);
    return (sl_lat >= 0) ? sl_lat : int'(n % 8'd11);
  endfunction

  // Expected {result, timeout} for one command under the current slave configuration.
  function automatic logic [32:0] model_rsp(logic [7:0] n, logic [31:0] a, logic [31:0] b);
    if (lat_of(n) > int'(Timeout)) return {32'h0, 1'b1};
    return {(sl_res_fixed ? sl_res_val : slave_fn(n, a, b)), 1'b0};
  endfunction

  bit          sl_pend = 1'b0;
  int          sl_cnt = 0;
  int          sl_cur = 0;
  logic [31:0] sl_out = 32'h0;

  // Latency 0 answers in the start cycle itself; result bus carries noise when not done.
  always @(negedge clock) begin
    ci_done   = 1'b0;
    ci_result = $urandom;
    if (ci_start === 1'b1) begin
      sl_pend = 1'b1;
      sl_cnt  = 0;
      sl_cur  = lat_of(ci_n);
      sl_out  = sl_res_fixed ? sl_res_val : slave_fn(ci_n, ci_value_a, ci_value_b);
    end
    if (sl_pend) begin
      if (sl_cnt == sl_cur) begin
        ci_done   = 1'b1;
        ci_result = sl_out;
        sl_pend   = 1'b0;
      end else begin
        sl_cnt++;
      end
    end
  end

  localparam logic [108:0] RstVec = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 1'b0};

  function automatic logic [108:0] out_vec();
    return {cmd_ready, rsp_valid, rsp_result, rsp_timeout, ci_start, ci_n, ci_value_a,
            ci_value_b, busy};
  endfunction

  task automatic push_cmd(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                          output int t);
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    cmd_valid   = 1'b1;
    cmd_ci_n    = n;
    cmd_value_a = a;
    cmd_value_b = b;
    t           = cyc;
    @(negedge clock);
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_start(output int s, output bit ok);
    ok = 1'b0;
    s  = -1;
    for (int i = 0; i < 60; i++) begin
      if (ci_start === 1'b1) begin
        ok = 1'b1;
        s  = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_rsp(output int r, output bit ok);
    ok = 1'b0;
    r  = -1;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        r  = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (out_vec() !== RstVec) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", out_vec(), RstVec);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  // One command with a fixed slave latency; checks issue timing, operand hold and response.
  task automatic test_latency(input string name, input int lat, input logic [31:0] res,
                              input logic [31:0] a, input logic [31:0] b, input bit exp_to);
    int t, s, r, exp_r;
    bit ok;
    logic [71:0] ops;
    logic [32:0] exp;
    sl_lat       = lat;
    sl_res_fixed = 1'b1;
    sl_res_val   = res;
    rsp_ready    = 1'b0;
    ops          = {8'h00, a, b};
    exp          = model_rsp(8'h00, a, b);
    exp_r        = exp_to ? int'(Timeout) + 1 : lat + 1;
    push_cmd(8'h00, a, b, t);
    wait_start(s, ok);
    checks++;
    if (!ok || s != t + 2) begin
      failures++;
      $display("FAIL %s start_cycle: got %0d expected %0d", name, s, t + 2);
    end
    checks++;
    if ({ci_n, ci_value_a, ci_value_b} !== ops) begin
      failures++;
      $display("FAIL %s issue_operands: got %h expected %h", name,
               {ci_n, ci_value_a, ci_value_b}, ops);
    end
    if (lat > 0) begin
      @(negedge clock);
      checks++;
      if ({ci_start, ci_n, ci_value_a, ci_value_b} !== {1'b0, ops}) begin
        failures++;
        $display("FAIL %s wait_hold: got %h expected %h", name,
                 {ci_start, ci_n, ci_value_a, ci_value_b}, {1'b0, ops});
      end
    end
    wait_rsp(r, ok);
    checks++;
    if (!ok || r != s + exp_r) begin
      failures++;
      $display("FAIL %s rsp_cycle: got %0d expected %0d", name, r, s + exp_r);
    end
    checks++;
    if ({rsp_result, rsp_timeout} !== exp) begin
      failures++;
      $display("FAIL %s rsp_data: got %h expected %h", name, {rsp_result, rsp_timeout}, exp);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    // Long enough for any late slave done to land while idle.
    repeat (6) @(negedge clock);
    checks++;
    if ({rsp_valid, busy, ci_value_a} !== {2'b00, a}) begin
      failures++;
      $display("FAIL %s after_rsp: got %h expected %h", name,
               {rsp_valid, busy, ci_value_a}, {2'b00, a});
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_q[$];
    logic [31:0] a_q[$];
    logic [32:0] e;
    logic [7:0]  n;
    logic [31:0] b;
    int n_acc, n_start, n_rsp;
    sl_lat       = 1;
    sl_res_fixed = 1'b0;
    rsp_ready    = 1'b0;
    n_acc        = 0;
    n_start      = 0;
    n_rsp        = 0;
    for (int i = 0; i < 12; i++) begin
      if (ci_start === 1'b1) begin
        n_start++;
        checks++;
        if (ci_value_a !== a_q[0]) begin
          failures++;
          $display("FAIL bp_issue_order: got %h expected %h", ci_value_a, a_q[0]);
        end
        void'(a_q.pop_front());
      end
      if (cmd_ready === 1'b1 && n_acc < 6) begin
        n = 8'($urandom);
        b = $urandom;
        cmd_valid = 1'b1; cmd_ci_n = n; cmd_value_a = 32'(n_acc); cmd_value_b = b;
        exp_q.push_back(model_rsp(n, 32'(n_acc), b));
        a_q.push_back(32'(n_acc));
        n_acc++;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    checks++;
    if ({n_acc, n_start, cmd_ready, rsp_valid} !== {32'd5, 32'd1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_full: got acc=%0d starts=%0d ready=%b valid=%b expected 5 1 0 1",
               n_acc, n_start, cmd_ready, rsp_valid);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 300 && n_rsp < 6; i++) begin
      if (ci_start === 1'b1) begin
        checks++;
        if (ci_value_a !== a_q[0]) begin
          failures++;
          $display("FAIL bp_issue_order: got %h expected %h", ci_value_a, a_q[0]);
        end
        void'(a_q.pop_front());
      end
      if (rsp_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if ({rsp_result, rsp_timeout} !== e) begin
          failures++;
          $display("FAIL bp_rsp%0d: got %h expected %h", n_rsp, {rsp_result, rsp_timeout}, e);
        end
        n_rsp++;
      end
      if (cmd_ready === 1'b1 && n_acc < 6) begin
        n = 8'($urandom);
        b = $urandom;
        cmd_valid = 1'b1; cmd_ci_n = n; cmd_value_a = 32'(n_acc); cmd_value_b = b;
        exp_q.push_back(model_rsp(n, 32'(n_acc), b));
        a_q.push_back(32'(n_acc));
        n_acc++;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (n_rsp != 6) begin
      failures++;
      $display("FAIL bp_drain_count: got %0d expected 6", n_rsp);
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [7:0]  n;
    logic [31:0] a, b;
    int n_acc, n_rsp;
    sl_lat       = -1;
    sl_res_fixed = 1'b0;
    n_acc        = 0;
    n_rsp        = 0;
    for (int i = 0; i < 3000 && n_rsp < N; i++) begin
      if (n_acc < N && cmd_ready === 1'b1 && $urandom_range(0, 1) == 1) begin
        n = 8'($urandom);
        a = $urandom;
        b = $urandom;
        cmd_valid = 1'b1; cmd_ci_n = n; cmd_value_a = a; cmd_value_b = b;
        exp_q.push_back(model_rsp(n, a, b));
        n_acc++;
      end else begin
        cmd_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (rsp_valid === 1'b1 && rsp_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        checks++;
        if ({rsp_result, rsp_timeout} !== e) begin
          failures++;
          $display("FAIL rand_rsp%0d: got %h expected %h", n_rsp, {rsp_result, rsp_timeout}, e);
        end
        n_rsp++;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (n_rsp != N) begin
      failures++;
      $display("FAIL rand_count: got %0d expected %0d", n_rsp, N);
    end
    repeat (15) @(negedge clock);
  endtask

  task automatic test_reset_mid_wait();
    int t, s;
    bit ok, saw;
    sl_lat       = 20;
    sl_res_fixed = 1'b0;
    rsp_ready    = 1'b1;
    push_cmd(8'h3C, $urandom, $urandom, t);
    wait_start(s, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_wait_start: got none expected start");
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (out_vec() !== RstVec) begin
      failures++;
      $display("FAIL rst_mid_values: got %h expected %h", out_vec(), RstVec);
    end
    reset = 1'b0;
    saw   = 1'b0;
    repeat (30) begin
      if (rsp_valid === 1'b1 || ci_start === 1'b1 || busy === 1'b1) saw = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_quiet: got activity=%b expected 0", saw);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency("single", 1, $urandom, 32'h105, 32'hDEADBEEF, 1'b0);
    test_latency("latency2", 2, 32'h12345678, 32'h005, $urandom, 1'b0);
    test_latency("same_cycle", 0, 32'hA5A5A5A5, $urandom, $urandom, 1'b0);
    test_latency("done_at_limit", int'(Timeout), $urandom, $urandom, $urandom, 1'b0);
    test_latency("timeout", 12, $urandom, $urandom, $urandom, 1'b1);
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
